// File: rtl/state_executor.sv
// state_executor
//
// Datapath responder for the fluxcore control unit. The controller hands
// over one decoded state code per handshake. This block executes it against
// the architectural state: PC, IR, MAR, four 8-bit GPRs, and the C/Z flags.
// It also drives the byte-wide memory bus, which may insert wait states.
//
// Ports
//   clk, reset_n      : rising-edge clock, asynchronous active-low reset
//   state/state_valid : state code handshake (ignored while busy or halted)
//   busy              : a memory access is in flight
//   instr, pc, flags  : IR, program counter, {C, Z}
//   halted, mem_err   : sticky halt / access-timeout indicators
//   mem_addr/rd/wr    : bus address (MAR) and registered strobes
//   mem_wdata         : write data (GPR selected by IR[1:0])
//   mem_rdata/ready   : read data and access-complete handshake
//   reg_sel/reg_data  : combinational debug read of a GPR

module state_executor #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] state,
  input  logic       state_valid,
  output logic       busy,
  output logic [7:0] instr,
  output logic [7:0] pc,
  output logic [1:0] flags,
  output logic       halted,
  output logic       mem_err,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready,
  input  logic [1:0] reg_sel,
  output logic [7:0] reg_data
);

  // state code encodings shared with the control unit
  localparam logic [7:0] STATE_NEXT       = 8'h00;
  localparam logic [7:0] STATE_FETCH_PC   = 8'h01;
  localparam logic [7:0] STATE_FETCH_INST = 8'h02;
  localparam logic [7:0] STATE_JUMP       = 8'h03;
  localparam logic [7:0] STATE_SET_REG    = 8'h04;
  localparam logic [7:0] STATE_ALU_EXEC   = 8'h05;
  localparam logic [7:0] STATE_ALU_STORE  = 8'h06;
  localparam logic [7:0] STATE_MOV_FETCH  = 8'h07;
  localparam logic [7:0] STATE_MOV_LOAD   = 8'h08;
  localparam logic [7:0] STATE_MOV_STORE  = 8'h09;
  localparam logic [7:0] STATE_HALT       = 8'h0A;

  // FSM encoding: bit 0 is the read strobe and bit 1 the write strobe.
  // This keeps both strobes as glitch-free register outputs.
  localparam logic [1:0] FSM_IDLE    = 2'b00;
  localparam logic [1:0] FSM_RD_WAIT = 2'b01;
  localparam logic [1:0] FSM_WR_WAIT = 2'b10;

  // destination of a pending read
  localparam logic [1:0] DST_IR  = 2'd0;
  localparam logic [1:0] DST_PC  = 2'd1;
  localparam logic [1:0] DST_GPR = 2'd2;
  localparam logic [1:0] DST_MAR = 2'd3;

  localparam logic [8:0] TIMEOUT_CNT = 9'(TIMEOUT);

  logic [1:0] fsm;
  logic [1:0] dst;
  logic [7:0] wait_cnt;
  logic [7:0] pc_q;
  logic [7:0] ir_q;
  logic [7:0] mar_q;
  logic [7:0] gpr [4];
  logic [8:0] tmp;
  logic       flag_c;
  logic       flag_z;
  logic [8:0] alu_res;
  logic       timeout_hit;

  assign busy      = (fsm != FSM_IDLE);
  assign mem_rd    = fsm[0];
  assign mem_wr    = fsm[1];
  assign instr     = ir_q;
  assign pc        = pc_q;
  assign flags     = {flag_c, flag_z};
  assign mem_addr  = mar_q;
  assign mem_wdata = gpr[ir_q[1:0]];
  assign reg_data  = gpr[reg_sel];

  // This counter includes the current wait cycle, so with TIMEOUT=15 the
  // access is abandoned on the 15th edge after acceptance.
  assign timeout_hit = (({1'b0, wait_cnt} + 9'd1) >= TIMEOUT_CNT);

  // ALU result. SUB is A + ~B + 1, so the carry out means "no borrow".
  always_comb begin
    alu_res = 9'd0;
    case (ir_q[5:4])
      2'b00:   alu_res = {1'b0, gpr[ir_q[3:2]]} + {1'b0, gpr[ir_q[1:0]]};
      2'b01:   alu_res = {1'b0, gpr[ir_q[3:2]]} + {1'b0, ~gpr[ir_q[1:0]]} + 9'd1;
      2'b10:   alu_res = {1'b0, gpr[ir_q[3:2]] & gpr[ir_q[1:0]]};
      default: alu_res = {1'b0, gpr[ir_q[3:2]] ^ gpr[ir_q[1:0]]};
    endcase
  end

  // Main sequencer.
  // A state code is accepted only in IDLE. Single-cycle states update
  // architectural state on the accepting edge. Memory states move to a
  // wait state, and that wait state completes on mem_ready or on timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm      <= FSM_IDLE;
      dst      <= DST_IR;
      wait_cnt <= 8'd0;
      pc_q     <= 8'd0;
      ir_q     <= 8'd0;
      mar_q    <= 8'd0;
      for (int i = 0; i < 4; i++) gpr[i] <= 8'd0;
      tmp      <= 9'd0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
      halted   <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      case (fsm)
        FSM_IDLE: begin
          if (state_valid && !halted) begin
            case (state)
              STATE_FETCH_PC, STATE_MOV_FETCH: begin
                mar_q <= pc_q;
                pc_q  <= pc_q + 8'd1;
              end
              STATE_FETCH_INST: begin
                fsm      <= FSM_RD_WAIT;
                dst      <= DST_IR;
                wait_cnt <= 8'd0;
              end
              STATE_JUMP: begin
                fsm      <= FSM_RD_WAIT;
                dst      <= DST_PC;
                wait_cnt <= 8'd0;
              end
              STATE_SET_REG: begin
                fsm      <= FSM_RD_WAIT;
                dst      <= DST_GPR;
                wait_cnt <= 8'd0;
              end
              STATE_MOV_LOAD: begin
                fsm      <= FSM_RD_WAIT;
                dst      <= DST_MAR;
                wait_cnt <= 8'd0;
              end
              STATE_MOV_STORE: begin
                fsm      <= FSM_WR_WAIT;
                wait_cnt <= 8'd0;
              end
              STATE_ALU_EXEC: begin
                tmp <= alu_res;
              end
              STATE_ALU_STORE: begin
                gpr[ir_q[3:2]] <= tmp[7:0];
                flag_z         <= (tmp[7:0] == 8'd0);
                flag_c         <= tmp[8];
              end
              STATE_HALT: begin
                halted <= 1'b1;
              end
              STATE_NEXT: begin
              end
              default: begin
              end
            endcase
          end
        end
        FSM_RD_WAIT, FSM_WR_WAIT: begin
          if (mem_ready) begin
            fsm <= FSM_IDLE;
            if (fsm == FSM_RD_WAIT) begin
              case (dst)
                DST_IR:  ir_q           <= mem_rdata;
                DST_PC:  pc_q           <= mem_rdata;
                DST_GPR: gpr[ir_q[1:0]] <= mem_rdata;
                default: mar_q          <= mem_rdata;
              endcase
            end
          end else if (timeout_hit) begin
            fsm     <= FSM_IDLE;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: fsm <= FSM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_state_executor.sv
// tb_state_executor
//
// Self-checking bench for state_executor. A stimulus table of state codes
// (with the memory wait cycles to use and the resulting architectural state)
// is applied in order. Each applied record is queued and then popped and
// compared once the executor goes idle again. Hand-written sequences then
// cover ready-while-idle, reset during a read, and halt.

module tb_state_executor;

  localparam logic [7:0] ST_NEXT       = 8'h00;
  localparam logic [7:0] ST_FETCH_PC   = 8'h01;
  localparam logic [7:0] ST_FETCH_INST = 8'h02;
  localparam logic [7:0] ST_JUMP       = 8'h03;
  localparam logic [7:0] ST_SET_REG    = 8'h04;
  localparam logic [7:0] ST_ALU_EXEC   = 8'h05;
  localparam logic [7:0] ST_ALU_STORE  = 8'h06;
  localparam logic [7:0] ST_MOV_FETCH  = 8'h07;
  localparam logic [7:0] ST_MOV_LOAD   = 8'h08;
  localparam logic [7:0] ST_MOV_STORE  = 8'h09;
  localparam logic [7:0] ST_HALT       = 8'h0A;

  typedef struct {
    string      name;
    logic [7:0] st;
    int         waitCyc;
    int         expCycles;
    bit         isWrite;
    logic [7:0] expPc;
    logic [7:0] expInstr;
    logic [7:0] expAddr;
    logic [1:0] expFlags;
    logic [1:0] sel;
    logic [7:0] expReg;
    logic       expErr;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] state = 8'h00;
  logic       state_valid = 1'b0;
  logic       busy;
  logic [7:0] instr;
  logic [7:0] pc;
  logic [1:0] flags;
  logic       halted;
  logic       mem_err;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic       mem_wr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ready = 1'b0;
  logic [1:0] reg_sel = 2'd0;
  logic [7:0] reg_data;

  logic [7:0] mem [256];
  int         waitCycles = 0;
  bit         forceReady = 1'b0;
  int         memCnt = 0;
  int         wrCount = 0;
  logic [7:0] lastWrAddr = 8'h00;
  logic [7:0] lastWrData = 8'h00;

  int         testsRun = 0;
  int         testsFailed = 0;
  int         obsCycles;
  int         obsRd;
  int         obsWr;
  vec_t       vecs [$];
  vec_t       expQ [$];

  state_executor #(.TIMEOUT(15)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .state      (state),
    .state_valid(state_valid),
    .busy       (busy),
    .instr      (instr),
    .pc         (pc),
    .flags      (flags),
    .halted     (halted),
    .mem_err    (mem_err),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .reg_sel    (reg_sel),
    .reg_data   (reg_data)
  );

  always #5 clk = ~clk;

  // Memory responder. It raises ready for the edge that follows
  // waitCycles low-ready edges of an active strobe.
  always @(negedge clk) begin
    if (mem_rd || mem_wr) begin
      memCnt    = memCnt + 1;
      mem_ready = (memCnt > waitCycles);
      mem_rdata = mem[mem_addr];
    end else begin
      memCnt    = 0;
      mem_ready = forceReady;
    end
  end

  // Log completed writes (this process sees the values from before the edge).
  always @(posedge clk) begin
    if (mem_wr && mem_ready) begin
      wrCount    = wrCount + 1;
      lastWrAddr = mem_addr;
      lastWrData = mem_wdata;
    end
  end

  function automatic vec_t mkVec(input string name, input logic [7:0] st,
                                 input int waitCyc, input int expCycles,
                                 input bit isWrite, input logic [7:0] expPc,
                                 input logic [7:0] expInstr, input logic [7:0] expAddr,
                                 input logic [1:0] expFlags, input logic [1:0] sel,
                                 input logic [7:0] expReg, input logic expErr);
    vec_t v;
    v.name = name; v.st = st; v.waitCyc = waitCyc; v.expCycles = expCycles;
    v.isWrite = isWrite; v.expPc = expPc; v.expInstr = expInstr; v.expAddr = expAddr;
    v.expFlags = expFlags; v.sel = sel; v.expReg = expReg; v.expErr = expErr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present one state code, queue its expected result, then follow the
  // access until busy falls (bounded at 300 cycles).
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    waitCycles  = v.waitCyc;
    reg_sel     = v.sel;
    state       = v.st;
    state_valid = 1'b1;
    expQ.push_back(v);
    @(posedge clk);
    #1;
    state_valid = 1'b0;
    obsCycles = 0;
    obsRd     = 0;
    obsWr     = 0;
    while (busy && obsCycles < 300) begin
      obsCycles++;
      obsRd += int'(mem_rd);
      obsWr += int'(mem_wr);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkTransaction();
    vec_t e;
    e = expQ.pop_front();
    checkOutput({e.name, ".busy_cycles"}, obsCycles, e.expCycles);
    checkOutput({e.name, ".rd_cycles"}, obsRd, e.isWrite ? 0 : e.expCycles);
    checkOutput({e.name, ".wr_cycles"}, obsWr, e.isWrite ? e.expCycles : 0);
    checkOutput({e.name, ".pc"}, pc, e.expPc);
    checkOutput({e.name, ".instr"}, instr, e.expInstr);
    checkOutput({e.name, ".mem_addr"}, mem_addr, e.expAddr);
    checkOutput({e.name, ".flags"}, flags, e.expFlags);
    checkOutput({e.name, ".reg"}, reg_data, e.expReg);
    checkOutput({e.name, ".mem_err"}, mem_err, e.expErr);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h5B; mem[8'h01] = 8'h02; mem[8'h02] = 8'hF0; mem[8'h03] = 8'h03;
    mem[8'h04] = 8'h20; mem[8'h05] = 8'h0B; mem[8'h06] = 8'h1A; mem[8'h07] = 8'h01;
    mem[8'h08] = 8'hAA; mem[8'h09] = 8'h40; mem[8'h0A] = 8'h27; mem[8'h0B] = 8'h3D;
    mem[8'h0C] = 8'hFF; mem[8'hFF] = 8'h99;

    //                  name           state          wait cyc wr  pc     instr  addr   flg   sel   reg    err
    vecs.push_back(mkVec("fpc0",       ST_FETCH_PC,   0,   0,  0, 8'h01, 8'h00, 8'h00, 2'b00, 2'd0, 8'h00, 1'b0));
    vecs.push_back(mkVec("finst0",     ST_FETCH_INST, 2,   3,  0, 8'h01, 8'h5B, 8'h00, 2'b00, 2'd0, 8'h00, 1'b0));
    vecs.push_back(mkVec("fpc1",       ST_FETCH_PC,   0,   0,  0, 8'h02, 8'h5B, 8'h01, 2'b00, 2'd0, 8'h00, 1'b0));
    vecs.push_back(mkVec("finst1",     ST_FETCH_INST, 1,   2,  0, 8'h02, 8'h02, 8'h01, 2'b00, 2'd0, 8'h00, 1'b0));
    vecs.push_back(mkVec("fpc2",       ST_FETCH_PC,   0,   0,  0, 8'h03, 8'h02, 8'h02, 2'b00, 2'd2, 8'h00, 1'b0));
    vecs.push_back(mkVec("setr2",      ST_SET_REG,    0,   1,  0, 8'h03, 8'h02, 8'h02, 2'b00, 2'd2, 8'hF0, 1'b0));
    vecs.push_back(mkVec("fpc3",       ST_FETCH_PC,   0,   0,  0, 8'h04, 8'h02, 8'h03, 2'b00, 2'd2, 8'hF0, 1'b0));
    vecs.push_back(mkVec("finst3",     ST_FETCH_INST, 0,   1,  0, 8'h04, 8'h03, 8'h03, 2'b00, 2'd3, 8'h00, 1'b0));
    vecs.push_back(mkVec("fpc4",       ST_FETCH_PC,   0,   0,  0, 8'h05, 8'h03, 8'h04, 2'b00, 2'd3, 8'h00, 1'b0));
    vecs.push_back(mkVec("setr3",      ST_SET_REG,    3,   4,  0, 8'h05, 8'h03, 8'h04, 2'b00, 2'd3, 8'h20, 1'b0));
    vecs.push_back(mkVec("fpc5",       ST_FETCH_PC,   0,   0,  0, 8'h06, 8'h03, 8'h05, 2'b00, 2'd2, 8'hF0, 1'b0));
    vecs.push_back(mkVec("finst5",     ST_FETCH_INST, 0,   1,  0, 8'h06, 8'h0B, 8'h05, 2'b00, 2'd2, 8'hF0, 1'b0));
    vecs.push_back(mkVec("add_exec",   ST_ALU_EXEC,   0,   0,  0, 8'h06, 8'h0B, 8'h05, 2'b00, 2'd2, 8'hF0, 1'b0));
    vecs.push_back(mkVec("add_store",  ST_ALU_STORE,  0,   0,  0, 8'h06, 8'h0B, 8'h05, 2'b10, 2'd2, 8'h10, 1'b0));
    vecs.push_back(mkVec("fpc6",       ST_FETCH_PC,   0,   0,  0, 8'h07, 8'h0B, 8'h06, 2'b10, 2'd2, 8'h10, 1'b0));
    vecs.push_back(mkVec("finst6",     ST_FETCH_INST, 1,   2,  0, 8'h07, 8'h1A, 8'h06, 2'b10, 2'd2, 8'h10, 1'b0));
    vecs.push_back(mkVec("sub_exec",   ST_ALU_EXEC,   0,   0,  0, 8'h07, 8'h1A, 8'h06, 2'b10, 2'd2, 8'h10, 1'b0));
    vecs.push_back(mkVec("sub_store",  ST_ALU_STORE,  0,   0,  0, 8'h07, 8'h1A, 8'h06, 2'b11, 2'd2, 8'h00, 1'b0));
    vecs.push_back(mkVec("fpc7",       ST_FETCH_PC,   0,   0,  0, 8'h08, 8'h1A, 8'h07, 2'b11, 2'd1, 8'h00, 1'b0));
    vecs.push_back(mkVec("finst7",     ST_FETCH_INST, 0,   1,  0, 8'h08, 8'h01, 8'h07, 2'b11, 2'd1, 8'h00, 1'b0));
    vecs.push_back(mkVec("fpc8",       ST_FETCH_PC,   0,   0,  0, 8'h09, 8'h01, 8'h08, 2'b11, 2'd1, 8'h00, 1'b0));
    vecs.push_back(mkVec("setr1",      ST_SET_REG,    0,   1,  0, 8'h09, 8'h01, 8'h08, 2'b11, 2'd1, 8'hAA, 1'b0));
    vecs.push_back(mkVec("mov_fetch",  ST_MOV_FETCH,  0,   0,  0, 8'h0A, 8'h01, 8'h09, 2'b11, 2'd1, 8'hAA, 1'b0));
    vecs.push_back(mkVec("mov_load",   ST_MOV_LOAD,   1,   2,  0, 8'h0A, 8'h01, 8'h40, 2'b11, 2'd1, 8'hAA, 1'b0));
    vecs.push_back(mkVec("mov_store",  ST_MOV_STORE,  2,   3,  1, 8'h0A, 8'h01, 8'h40, 2'b11, 2'd1, 8'hAA, 1'b0));
    vecs.push_back(mkVec("fpc10",      ST_FETCH_PC,   0,   0,  0, 8'h0B, 8'h01, 8'h0A, 2'b11, 2'd1, 8'hAA, 1'b0));
    vecs.push_back(mkVec("finst10",    ST_FETCH_INST, 0,   1,  0, 8'h0B, 8'h27, 8'h0A, 2'b11, 2'd1, 8'hAA, 1'b0));
    vecs.push_back(mkVec("and_exec",   ST_ALU_EXEC,   0,   0,  0, 8'h0B, 8'h27, 8'h0A, 2'b11, 2'd1, 8'hAA, 1'b0));
    vecs.push_back(mkVec("and_store",  ST_ALU_STORE,  0,   0,  0, 8'h0B, 8'h27, 8'h0A, 2'b00, 2'd1, 8'h20, 1'b0));
    vecs.push_back(mkVec("fpc11",      ST_FETCH_PC,   0,   0,  0, 8'h0C, 8'h27, 8'h0B, 2'b00, 2'd3, 8'h20, 1'b0));
    vecs.push_back(mkVec("finst11",    ST_FETCH_INST, 0,   1,  0, 8'h0C, 8'h3D, 8'h0B, 2'b00, 2'd3, 8'h20, 1'b0));
    vecs.push_back(mkVec("xor_exec",   ST_ALU_EXEC,   0,   0,  0, 8'h0C, 8'h3D, 8'h0B, 2'b00, 2'd3, 8'h20, 1'b0));
    vecs.push_back(mkVec("xor_store",  ST_ALU_STORE,  0,   0,  0, 8'h0C, 8'h3D, 8'h0B, 2'b01, 2'd3, 8'h00, 1'b0));
    vecs.push_back(mkVec("fpc12",      ST_FETCH_PC,   0,   0,  0, 8'h0D, 8'h3D, 8'h0C, 2'b01, 2'd1, 8'h20, 1'b0));
    vecs.push_back(mkVec("jump",       ST_JUMP,       0,   1,  0, 8'hFF, 8'h3D, 8'h0C, 2'b01, 2'd1, 8'h20, 1'b0));
    vecs.push_back(mkVec("fpc_wrap",   ST_FETCH_PC,   0,   0,  0, 8'h00, 8'h3D, 8'hFF, 2'b01, 2'd1, 8'h20, 1'b0));
    vecs.push_back(mkVec("next_nop",   ST_NEXT,       0,   0,  0, 8'h00, 8'h3D, 8'hFF, 2'b01, 2'd1, 8'h20, 1'b0));
    vecs.push_back(mkVec("to_edge",    ST_FETCH_INST, 14, 15,  0, 8'h00, 8'h99, 8'hFF, 2'b01, 2'd1, 8'h20, 1'b0));
    vecs.push_back(mkVec("timeout",    ST_FETCH_INST, 100,15,  0, 8'h00, 8'h99, 8'hFF, 2'b01, 2'd1, 8'h20, 1'b1));

    // reset state
    reset_n = 1'b0;
    #2;
    checkOutput("reset.pc", pc, 8'h00);
    checkOutput("reset.instr", instr, 8'h00);
    checkOutput("reset.busy", busy, 1'b0);
    checkOutput("reset.mem_rd", mem_rd, 1'b0);
    checkOutput("reset.mem_wr", mem_wr, 1'b0);
    checkOutput("reset.halted", halted, 1'b0);
    checkOutput("reset.mem_err", mem_err, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkTransaction();
    end

    checkOutput("mov.write_count", wrCount, 1);
    checkOutput("mov.write_addr", lastWrAddr, 8'h40);
    checkOutput("mov.write_data", lastWrData, 8'hAA);

    // mem_ready while idle must not start or complete anything
    @(negedge clk);
    forceReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_ready.busy", busy, 1'b0);
    checkOutput("idle_ready.pc", pc, 8'h00);
    checkOutput("idle_ready.instr", instr, 8'h99);
    @(negedge clk);
    forceReady = 1'b0;

    // reset asserted in the middle of a read wait
    @(negedge clk);
    waitCycles  = 100;
    state       = ST_FETCH_INST;
    state_valid = 1'b1;
    @(posedge clk);
    #1;
    state_valid = 1'b0;
    checkOutput("pre_reset.mem_rd", mem_rd, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_reset.mem_rd", mem_rd, 1'b0);
    checkOutput("mid_reset.busy", busy, 1'b0);
    checkOutput("mid_reset.instr", instr, 8'h00);
    checkOutput("mid_reset.mem_addr", mem_addr, 8'h00);
    checkOutput("mid_reset.flags", flags, 2'b00);
    checkOutput("mid_reset.mem_err", mem_err, 1'b0);
    for (int k = 0; k < 4; k++) begin
      reg_sel = 2'(k);
      #1;
      checkOutput($sformatf("mid_reset.r%0d", k), reg_data, 8'h00);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // halt blocks further state codes
    applyStimulus(mkVec("post_reset_fpc", ST_FETCH_PC, 0, 0, 0, 8'h01, 8'h00, 8'h00, 2'b00, 2'd0, 8'h00, 1'b0));
    checkTransaction();
    applyStimulus(mkVec("halt", ST_HALT, 0, 0, 0, 8'h01, 8'h00, 8'h00, 2'b00, 2'd0, 8'h00, 1'b0));
    checkTransaction();
    checkOutput("halt.halted", halted, 1'b1);
    applyStimulus(mkVec("halted_fpc", ST_FETCH_PC, 0, 0, 0, 8'h01, 8'h00, 8'h00, 2'b00, 2'd0, 8'h00, 1'b0));
    checkTransaction();
    checkOutput("halted_fpc.halted", halted, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/state_executor.md
# state_executor

Datapath responder for the fluxcore control unit. Accepts one decoded state code per handshake, executes it against the architectural state (PC, IR, MAR, four 8-bit GPRs, Z/C flags), drives the byte-wide memory bus with wait-state support, and returns the fetched instruction byte to the controller. It is the execute side of the control-state interface: the control unit sequences, this block acts.

## Interface

- `TIMEOUT`, default 15: maximum cycles to wait for `mem_ready` before abandoning an access (1..255).
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `state` in 8: state code; encodings are the `STATE_*` macros in `parameters.sv`.
- `state_valid` in 1: `state` is presented this cycle.
- `busy` out 1: executor is mid-access; while high, `state_valid` is ignored.
- `instr` out 8: IR contents, consumed by the control unit.
- `pc` out 8: program counter.
- `flags` out 2: {C, Z}.
- `halted` out 1: sticky halt indicator.
- `mem_err` out 1: sticky timeout indicator.
- `mem_addr` out 8: bus address (= MAR).
- `mem_rd`, `mem_wr` out 1 each: registered strobes.
- `mem_wdata` out 8: write data.
- `mem_rdata` in 8: read data, valid when `mem_ready` is high.
- `mem_ready` in 1: access complete.
- `reg_sel` in 2 / `reg_data` out 8: combinational debug read of GPR `r[reg_sel]`.

## Operation

- Accept: rising edge with `state_valid=1`, `busy=0`, `halted=0`. Otherwise the state code is dropped.
- IR field use:
  - ALU op = IR[5:4]: 00 ADD, 01 SUB, 10 AND, 11 XOR.
  - dst/srcA = IR[3:2].
  - srcB / LDI/MOV register = IR[1:0].
- Per state:
  - FETCH_PC: MAR<=PC; PC<=PC+1, wrapping 0xFF->0x00. Single cycle.
  - FETCH_INST: read mem[MAR]; IR<=rdata.
  - JUMP: read mem[MAR]; PC<=rdata.
  - SET_REG: read mem[MAR]; r[IR[1:0]]<=rdata.
  - ALU_EXEC: tmp <= 9-bit result of r[IR[3:2]] op r[IR[1:0]]. SUB is computed as A + ~B + 1, so C = no-borrow. For AND/XOR, tmp[8]=0. Single cycle.
  - ALU_STORE: r[IR[3:2]]<=tmp[7:0]; Z<=(tmp[7:0]==0); C<=tmp[8]. Single cycle.
  - MOV_FETCH: MAR<=PC; PC<=PC+1. Single cycle.
  - MOV_LOAD: read mem[MAR]; MAR<=rdata (indirect address).
  - MOV_STORE: write r[IR[1:0]] to mem[MAR].
  - HALT: halted<=1. Single cycle.
  - NEXT and unknown codes: no-op.
- Internal FSM, states IDLE, RD_WAIT, WR_WAIT:
  - IDLE -> RD_WAIT on an accepted read state. Latch the destination kind (IR / PC / GPR / MAR).
  - IDLE -> WR_WAIT on an accepted MOV_STORE.
  - *_WAIT -> IDLE on an edge with `mem_ready=1`. Reads capture `mem_rdata` into the latched destination on that edge.
  - *_WAIT -> IDLE when the wait counter reaches TIMEOUT. Set `mem_err`; leave the destination unchanged.
- `busy` = (FSM != IDLE). `mem_rd` is high exactly in RD_WAIT, `mem_wr` exactly in WR_WAIT. `mem_addr`/`mem_wdata` are stable throughout the wait.
- `halted` and `mem_err` clear only on reset.

## Timing

- Reset (async on `reset_n` low): PC, IR, MAR, r0..r3, tmp, flags = 0; FSM = IDLE; busy, mem_rd, mem_wr, halted, mem_err = 0; wait counter = 0. Strobes drop immediately without waiting for a clock edge, including mid-access.
- Single-cycle states take effect on the accepting edge and are visible the next cycle.
- Memory states:
  - Accept at edge N.
  - `mem_rd`/`mem_wr` high from N to the completing edge M.
  - `mem_ready` sampled at edges N+1 onward. Minimum access is 1 wait cycle; `busy` is high for M−N cycles.
  - Destination is updated at M, and `busy`=0 after M.
  - `mem_ready` high while IDLE is ignored.
- Wait counter: reset to 0 on entry, +1 per cycle in WAIT. Timeout fires at the edge where the count equals TIMEOUT and `mem_ready=0`. If `mem_ready=1` arrives on that same edge, the access completes normally and no error is set.
- Back-to-back: a new state may be accepted on the same edge that returns the FSM to IDLE only if `busy` was 0 before that edge. Otherwise it is accepted on the next edge.

## Test plan

- Reset with PC=0x00, then FETCH_PC + FETCH_INST with mem[0x00]=0x5B and 2 wait cycles. Response: `mem_addr`=0x00, `mem_rd` high for 3 cycles, `instr`=0x5B, `pc`=0x01, `busy` low afterwards.
- ALU sequence:
  - Preload r2=0xF0, r3=0x20 via SET_REG, then ALU_EXEC/ALU_STORE with IR=0x0B (ADD r2,r3). Required: r2=0x10, C=1, Z=0.
  - Then IR=0x1A (SUB r2,r2). Required: r2=0x00, Z=1, C=1.
- PC=0xFF, then FETCH_PC. Required: MAR=0xFF, `pc`=0x00.
- MOV with IR r1=0xAA, operand byte at PC giving address 0x40. Required: write strobe with `mem_addr`=0x40, `mem_wdata`=0xAA; `pc` advanced by 1.
- Timeout case: TIMEOUT=15 and `mem_ready` held low. Required: `mem_rd` drops after 15 wait cycles, `mem_err`=1, IR unchanged.
- Timeout boundary: `mem_ready` rising on cycle 15 completes the access with `mem_err`=0.
- Reset and halt:
  - Assert `reset_n` low mid-RD_WAIT. Required: `mem_rd`=0 before the next edge, all registers 0.
  - Issue HALT, then FETCH_PC. Required: `halted`=1, `pc` unchanged.
